// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the memory port arbiter.
// Signals only, no logic and no latency of its own.
// No backpressure of its own: requesters hold req until gnt (the slave modport view).
// Ports: fetch (if_*), load/store (ls_*), memory pins (mem_*).
// Modports: slave = arbiter view; master = requester/memory view (testbench).
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [AWIDTH-1:0] ls_addr_i;
  logic [DWIDTH-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DWIDTH-1:0] ls_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  mem_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output mem_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and load/store (read/write).
// Latency: gnt -> mem enable 1 cycle; gnt -> rvalid 2+MEM_LAT cycles; stores retire in 2.
// Backpressure: grants only in IDLE, one transaction outstanding; other requests stay pending.
// Ports: clk, rst (sync, active high), bus (slave modport: fetch, load/store, memory pins).
module mem_port_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int MEM_LAT = 1,
  parameter int RR_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  // Counter needs at least one bit even when MEM_LAT=0 (it is then unused).
  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;

  logic              grant_if;
  logic              grant_ls;
  logic              grant_any;
  logic              grant_store;
  logic              capture;
  logic              if_rvalid;
  logic              ls_rvalid;

  logic              win_ls;      // winner of the transaction in flight
  logic              last_ls;     // winner of the most recent grant
  logic              we_q;        // transaction in flight is a store
  logic [CW-1:0]     cnt;

  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_data_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] ls_rdata_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (we_q)              state_nxt = S_IDLE;
        else if (MEM_LAT == 0) state_nxt = S_RESP;
        else                   state_nxt = S_WAIT;
      end
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: grants are combinational in IDLE; held off during reset so that
  // nothing is acknowledged that the reset would immediately discard.
  always_comb begin
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (bus.if_req_i && bus.ls_req_i) begin
        // Round-robin hands contention to whoever did not win last; otherwise LS first.
        if (RR_EN != 0 && last_ls) grant_if = 1'b1;
        else                       grant_ls = 1'b1;
      end else if (bus.if_req_i) begin
        grant_if = 1'b1;
      end else if (bus.ls_req_i) begin
        grant_ls = 1'b1;
      end
    end
    if (state == S_RESP) begin
      if_rvalid = !win_ls;
      ls_rvalid = win_ls;
    end
  end

  assign grant_any   = grant_if | grant_ls;
  assign grant_store = grant_ls & bus.ls_we_i;

  // Read data is sampled on the last cycle before RESP: end of ISSUE for a
  // combinational memory, otherwise when the WAIT countdown reaches zero.
  assign capture = (state == S_ISSUE && !we_q && MEM_LAT == 0) ||
                   (state == S_WAIT && cnt == '0);

  // Datapath. Memory pins are loaded at the grant edge so they are valid for exactly
  // the ISSUE cycle; grants only occur in IDLE, so they fall back to 0 one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_ls     <= 1'b0;
      last_ls    <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (grant_any) begin
        win_ls  <= grant_ls;
        last_ls <= grant_ls;
        we_q    <= grant_store;
      end
      mem_addr_q <= grant_any ? (grant_ls ? bus.ls_addr_i : bus.if_addr_i) : '0;
      mem_re_q   <= grant_any & ~grant_store;
      mem_we_q   <= grant_store;
      mem_data_q <= grant_store ? bus.ls_wdata_i : '0;

      if (state == S_ISSUE)                 cnt <= CNT_LOAD;
      else if (state == S_WAIT && cnt != '0) cnt <= cnt - 1'b1;

      if (capture) begin
        if (win_ls) ls_rdata_q <= bus.mem_data_i;
        else        if_rdata_q <= bus.mem_data_i;
      end
    end
  end

  assign bus.if_gnt_o       = grant_if;
  assign bus.ls_gnt_o       = grant_ls;
  assign bus.if_rvalid_o    = if_rvalid;
  assign bus.ls_rvalid_o    = ls_rvalid;
  assign bus.if_rdata_o     = if_rdata_q;
  assign bus.ls_rdata_o     = ls_rdata_q;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.mem_read_en_o  = mem_re_q;
  assign bus.mem_write_en_o = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: dut_a (MEM_LAT=1, round-robin) and dut_b (MEM_LAT=3, fixed LS priority).
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Memory models return data only in the cycle it is valid; other cycles carry a marker.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus_a ();
  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus_b ();

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(1), .RR_EN(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(3), .RR_EN(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;
  localparam logic [31:0] MSK = 32'h5A5A_5A5A;

  // Memory contents: one preset word, the last store, else address xor a mask.
  function automatic logic [31:0] mem_rd(input logic [31:0] addr, input logic seen,
                                         input logic [31:0] wa, input logic [31:0] wd);
    if (addr == 32'h0100_0000) return 32'h0000_0013;
    if (seen && addr == wa) return wd;
    return addr ^ MSK;
  endfunction

  // Memory for dut_a: one-cycle read latency.
  logic        a_vld  = 1'b0;
  logic        a_seen = 1'b0;
  logic [31:0] a_raddr = 32'h0;
  logic [31:0] a_wa = 32'h0;
  logic [31:0] a_wd = 32'h0;
  always @(posedge clk) begin
    a_vld   <= bus_a.mem_read_en_o;
    a_raddr <= bus_a.mem_addr_o;
    if (bus_a.mem_write_en_o) begin
      a_seen <= 1'b1;
      a_wa   <= bus_a.mem_addr_o;
      a_wd   <= bus_a.mem_data_o;
    end
  end
  assign bus_a.mem_data_i = a_vld ? mem_rd(a_raddr, a_seen, a_wa, a_wd) : BAD;

  // Memory for dut_b: three-cycle read latency, read-only traffic.
  logic [2:0]  b_vld = 3'b000;
  logic [31:0] b_raddr [3];
  always @(posedge clk) begin
    b_vld      <= {b_vld[1:0], bus_b.mem_read_en_o};
    b_raddr[0] <= bus_b.mem_addr_o;
    b_raddr[1] <= b_raddr[0];
    b_raddr[2] <= b_raddr[1];
  end
  assign bus_b.mem_data_i = b_vld[2] ? mem_rd(b_raddr[2], 1'b0, 32'h0, 32'h0) : BAD;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // flags = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_read_en, mem_write_en}
  task automatic check_a(input string tag, input logic [5:0] ef, input logic [31:0] ma,
                         input logic [31:0] md, input logic [31:0] ird, input logic [31:0] lrd);
    chk({tag, " flags"}, {26'd0, bus_a.if_gnt_o, bus_a.ls_gnt_o, bus_a.if_rvalid_o,
        bus_a.ls_rvalid_o, bus_a.mem_read_en_o, bus_a.mem_write_en_o}, {26'd0, ef});
    chk({tag, " mem_addr"}, bus_a.mem_addr_o, ma);
    chk({tag, " mem_data"}, bus_a.mem_data_o, md);
    chk({tag, " if_rdata"}, bus_a.if_rdata_o, ird);
    chk({tag, " ls_rdata"}, bus_a.ls_rdata_o, lrd);
  endtask

  task automatic check_b(input string tag, input logic [5:0] ef, input logic [31:0] ma,
                         input logic [31:0] md, input logic [31:0] ird, input logic [31:0] lrd);
    chk({tag, " flags"}, {26'd0, bus_b.if_gnt_o, bus_b.ls_gnt_o, bus_b.if_rvalid_o,
        bus_b.ls_rvalid_o, bus_b.mem_read_en_o, bus_b.mem_write_en_o}, {26'd0, ef});
    chk({tag, " mem_addr"}, bus_b.mem_addr_o, ma);
    chk({tag, " mem_data"}, bus_b.mem_data_o, md);
    chk({tag, " if_rdata"}, bus_b.if_rdata_o, ird);
    chk({tag, " ls_rdata"}, bus_b.ls_rdata_o, lrd);
  endtask

  // req = {if_req, ls_req, ls_we}
  typedef struct {
    logic [2:0]  req;
    logic [31:0] if_addr;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [5:0]  ef;
    logic [31:0] e_maddr;
    logic [31:0] e_mdata;
    logic [31:0] e_ird;
    logic [31:0] e_lrd;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  initial begin
    // Fetch read (0x13 at 0x01000000), then store/load at 0x10, then RR contention.
    vecs[0]  = '{3'b100, 32'h0100_0000, 32'h0,   32'h0,         6'b100000, 32'h0,         32'h0,         32'h0,         32'h0};
    vecs[1]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000010, 32'h0100_0000, 32'h0,         32'h0,         32'h0};
    vecs[2]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         32'h0,         32'h0,         32'h0};
    vecs[3]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b001000, 32'h0,         32'h0,         32'h13,        32'h0};
    vecs[4]  = '{3'b011, 32'h0,         32'h10,  32'hDEAD_BEEF, 6'b010000, 32'h0,         32'h0,         32'h13,        32'h0};
    vecs[5]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000001, 32'h10,        32'hDEAD_BEEF, 32'h13,        32'h0};
    vecs[6]  = '{3'b010, 32'h0,         32'h10,  32'h0,         6'b010000, 32'h0,         32'h0,         32'h13,        32'h0};
    vecs[7]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000010, 32'h10,        32'h0,         32'h13,        32'h0};
    vecs[8]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         32'h0,         32'h13,        32'h0};
    vecs[9]  = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000100, 32'h0,         32'h0,         32'h13,        32'hDEAD_BEEF};
    vecs[10] = '{3'b110, 32'h100,       32'h200, 32'h0,         6'b100000, 32'h0,         32'h0,         32'h13,        32'hDEAD_BEEF};
    vecs[11] = '{3'b110, 32'h104,       32'h200, 32'h0,         6'b000010, 32'h100,       32'h0,         32'h13,        32'hDEAD_BEEF};
    vecs[12] = '{3'b110, 32'h104,       32'h200, 32'h0,         6'b000000, 32'h0,         32'h0,         32'h13,        32'hDEAD_BEEF};
    vecs[13] = '{3'b110, 32'h104,       32'h200, 32'h0,         6'b001000, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'hDEAD_BEEF};
    vecs[14] = '{3'b110, 32'h104,       32'h200, 32'h0,         6'b010000, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'hDEAD_BEEF};
    vecs[15] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b000010, 32'h200,       32'h0,         32'h5A5A_5B5A, 32'hDEAD_BEEF};
    vecs[16] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b000000, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'hDEAD_BEEF};
    vecs[17] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b000100, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'h5A5A_585A};
    vecs[18] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b100000, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'h5A5A_585A};
    vecs[19] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b000010, 32'h104,       32'h0,         32'h5A5A_5B5A, 32'h5A5A_585A};
    vecs[20] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b000000, 32'h0,         32'h0,         32'h5A5A_5B5A, 32'h5A5A_585A};
    vecs[21] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b001000, 32'h0,         32'h0,         32'h5A5A_5B5E, 32'h5A5A_585A};
    vecs[22] = '{3'b110, 32'h104,       32'h204, 32'h0,         6'b010000, 32'h0,         32'h0,         32'h5A5A_5B5E, 32'h5A5A_585A};
    vecs[23] = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000010, 32'h204,       32'h0,         32'h5A5A_5B5E, 32'h5A5A_585A};
    vecs[24] = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         32'h0,         32'h5A5A_5B5E, 32'h5A5A_585A};
    vecs[25] = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000100, 32'h0,         32'h0,         32'h5A5A_5B5E, 32'h5A5A_585E};
    vecs[26] = '{3'b000, 32'h0,         32'h0,   32'h0,         6'b000000, 32'h0,         32'h0,         32'h5A5A_5B5E, 32'h5A5A_585E};

    bus_a.if_req_i = 1'b0; bus_a.if_addr_i = 32'h0;
    bus_a.ls_req_i = 1'b0; bus_a.ls_we_i = 1'b0; bus_a.ls_addr_i = 32'h0; bus_a.ls_wdata_i = 32'h0;
    bus_b.if_req_i = 1'b0; bus_b.if_addr_i = 32'h0;
    bus_b.ls_req_i = 1'b0; bus_b.ls_we_i = 1'b0; bus_b.ls_addr_i = 32'h0; bus_b.ls_wdata_i = 32'h0;
    rst_a = 1'b1;
    rst_b = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_a("reset a", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    check_b("reset b", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Table: one row per clock cycle on dut_a.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus_a.if_req_i   = vecs[i].req[2];
      bus_a.ls_req_i   = vecs[i].req[1];
      bus_a.ls_we_i    = vecs[i].req[0];
      bus_a.if_addr_i  = vecs[i].if_addr;
      bus_a.ls_addr_i  = vecs[i].ls_addr;
      bus_a.ls_wdata_i = vecs[i].ls_wdata;
      #1;
      check_a($sformatf("vec%0d", i), vecs[i].ef, vecs[i].e_maddr, vecs[i].e_mdata,
              vecs[i].e_ird, vecs[i].e_lrd);
    end

    // Reset for two cycles in the middle of a fetch, with a load request pending.
    @(negedge clk);
    bus_a.if_req_i = 1'b1; bus_a.if_addr_i = 32'h300;
    #1;
    check_a("t1 gnt", 6'b100000, 32'h0, 32'h0, 32'h5A5A_5B5E, 32'h5A5A_585E);
    @(negedge clk);
    bus_a.if_req_i = 1'b0;
    bus_a.ls_req_i = 1'b1; bus_a.ls_we_i = 1'b0; bus_a.ls_addr_i = 32'h400;
    #1;
    check_a("t1 issue", 6'b000010, 32'h300, 32'h0, 32'h5A5A_5B5E, 32'h5A5A_585E);
    rst_a = 1'b1;
    @(negedge clk); #1;
    check_a("t1 rst0", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); #1;
    check_a("t1 rst1", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_a = 1'b0;
    #1;
    check_a("t1 regnt", 6'b010000, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus_a.ls_req_i = 1'b0;
      #1;
      chk($sformatf("t1 ls_rvalid k%0d", k), {31'd0, bus_a.ls_rvalid_o}, {31'd0, (k == 3)});
      chk($sformatf("t1 if_rvalid k%0d", k), {31'd0, bus_a.if_rvalid_o}, 32'h0);
      if (k == 1) chk("t1 mem_addr", bus_a.mem_addr_o, 32'h400);
    end
    chk("t1 ls_rdata", bus_a.ls_rdata_o, 32'h5A5A_5E5A);

    // dut_b: load with MEM_LAT=3, reset lands in WAIT.
    @(negedge clk);
    bus_b.ls_req_i = 1'b1; bus_b.ls_we_i = 1'b0; bus_b.ls_addr_i = 32'h40;
    #1;
    check_b("t5 gnt", 6'b010000, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    bus_b.ls_req_i = 1'b0;
    #1;
    check_b("t5 issue", 6'b000010, 32'h40, 32'h0, 32'h0, 32'h0);
    @(negedge clk); #1;
    check_b("t5 wait", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_b = 1'b1;
    @(negedge clk); #1;
    check_b("t5 rst", 6'b000000, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t5 dropped k%0d", k), {31'd0, bus_b.ls_rvalid_o}, 32'h0);
    end
    @(negedge clk);
    bus_b.ls_req_i = 1'b1; bus_b.ls_addr_i = 32'h44;
    #1;
    chk("t5 regnt", {31'd0, bus_b.ls_gnt_o}, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus_b.ls_req_i = 1'b0;
      #1;
      chk($sformatf("t5 ls_rvalid k%0d", k), {31'd0, bus_b.ls_rvalid_o}, {31'd0, (k == 5)});
    end
    chk("t5 ls_rdata", bus_b.ls_rdata_o, 32'h5A5A_5A1E);

    // dut_b fixed priority: both requests held for six transactions.
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      bus_b.if_req_i = 1'b1; bus_b.if_addr_i = 32'h500;
      bus_b.ls_req_i = 1'b1; bus_b.ls_we_i = 1'b0; bus_b.ls_addr_i = 32'h600;
      #1;
      chk($sformatf("t6 if_gnt c%0d", c), {31'd0, bus_b.if_gnt_o}, 32'h0);
      chk($sformatf("t6 ls_gnt c%0d", c), {31'd0, bus_b.ls_gnt_o}, {31'd0, (c % 6 == 0)});
      chk($sformatf("t6 ls_rvalid c%0d", c), {31'd0, bus_b.ls_rvalid_o}, {31'd0, (c % 6 == 5)});
    end
    chk("t6 ls_rdata", bus_b.ls_rdata_o, 32'h5A5A_5C5A);
    chk("t6 if_rdata", bus_b.if_rdata_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
